// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART frame transmitter and the matching
// receiver: the 3-bit frame state encoding, the line levels, and a small
// sizing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    INSTR  = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  // Level of the serial line when nothing is being sent (also the stop level).
  localparam logic LINE_IDLE = 1'b1;
  // Level of the start bit.
  localparam logic LINE_START = 1'b0;

  // Largest of three field lengths; used to size the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer. While enabled it raises tick for one
// cycle every CLKS_PER_BIT cycles. A restart pulse realigns the period so
// that the first tick arrives CLKS_PER_BIT cycles after the restart edge.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running period counter, reloaded at each bit boundary or on restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises one frame per accepted request:
//   start(0), dado LSB first, instrucao LSB first, [even parity], stop bits(1).
// Optional feature: define UART_FRAME_TX_PARITY_EN to insert an even-parity
// bit (XOR of all payload bits) between the instruction field and the stops.
// ready is high only in IDLE; busy is its inverse. The line is registered, so
// the start bit appears the cycle after the accept edge.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int INSTR_W      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  output logic               ready,
  input  logic [DATA_W-1:0]  dado,
  input  logic [INSTR_W-1:0] instrucao,
  output logic               info_saida,
  output logic               busy
);

  localparam int PAY_W   = DATA_W + INSTR_W;
  localparam int CNT_MAX = max3(DATA_W, INSTR_W, STOP_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_BITS - 1);

  uart_state_e      state;
  logic [PAY_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             tick;
  logic             accept;
`ifdef UART_FRAME_TX_PARITY_EN
  logic             par;
`endif

  assign accept = valid & ready;
  assign busy   = ~ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .en     (busy),
    .tick   (tick)
  );

  // Frame FSM: walks the fields on bit-boundary ticks and registers the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      info_saida <= LINE_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          info_saida <= LINE_IDLE;
          if (accept) begin
            state      <= START;
            ready      <= 1'b0;
            info_saida <= LINE_START;
            shreg      <= {instrucao, dado};
            bit_cnt    <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
            par        <= ^{instrucao, dado};
`endif
          end
        end
        START: begin
          if (tick) begin
            state      <= DATA;
            info_saida <= shreg[0];
            shreg      <= shreg >> 1;
            bit_cnt    <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            info_saida <= shreg[0];
            shreg      <= shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
              state   <= INSTR;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        INSTR: begin
          if (tick) begin
            if (bit_cnt == INSTR_LAST) begin
              bit_cnt <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
              state      <= PARITY;
              info_saida <= par;
`else
              state      <= STOP;
              info_saida <= LINE_IDLE;
`endif
            end else begin
              info_saida <= shreg[0];
              shreg      <= shreg >> 1;
              bit_cnt    <= bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef UART_FRAME_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state      <= STOP;
            info_saida <= LINE_IDLE;
            bit_cnt    <= '0;
          end
        end
`endif
        STOP: begin
          info_saida <= LINE_IDLE;
          if (tick) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              ready   <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          ready      <= 1'b1;
          info_saida <= LINE_IDLE;
          bit_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx. Two instances share the
// clock and reset: a 4/4-bit, 1-stop instance and an 8/8-bit, 2-stop one,
// both at 4 clocks per bit. Expected line sequences are hand-written strings,
// first transmitted bit on the left.
module tb_uart_frame_tx;

  localparam int C = 4;

`ifdef UART_FRAME_TX_PARITY_EN
  localparam string S_A3  = "00101110001";
  localparam string S_B1  = "01000110011";
  localparam string S_BF  = "01111110001";
  localparam string S_W8  = "01010101000000001111";
`else
  localparam string S_A3  = "0010111001";
  localparam string S_B1  = "0100011001";
  localparam string S_BF  = "0111111001";
  localparam string S_W8  = "0101010100000000111";
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       valid0 = 1'b0;
  logic [3:0] dado0  = '0;
  logic [3:0] instr0 = '0;
  logic       ready0, line0, busy0;

  logic       valid1 = 1'b0;
  logic [7:0] dado1  = '0;
  logic [7:0] instr1 = '0;
  logic       ready1, line1, busy1;

  int   total = 0;
  int   bad   = 0;
  int   len   = 0;
  int   busy_err = 0;
  int   lowcnt = 0;
  logic samp [0:127];

  always #5 clk = ~clk;

  uart_frame_tx #(.DATA_W(4), .INSTR_W(4), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .valid(valid0), .ready(ready0), .dado(dado0),
    .instrucao(instr0), .info_saida(line0), .busy(busy0)
  );

  uart_frame_tx #(.DATA_W(8), .INSTR_W(8), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .dado(dado1),
    .instrucao(instr1), .info_saida(line1), .busy(busy1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after an accept edge: records the line on every busy cycle
  // until ready returns (bounded), leaving the bench on the first idle negedge.
  task automatic capture(input int which);
    logic r, l, b;
    len = 0;
    busy_err = 0;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      r = (which == 0) ? ready0 : ready1;
      l = (which == 0) ? line0  : line1;
      b = (which == 0) ? busy0  : busy1;
      if (r === 1'b1) break;
      if (b !== ~r) busy_err++;
      samp[j] = l;
      len++;
    end
  endtask

  // Compares captured frame against a bit string: length, each bit held C cycles.
  task automatic check_frame(input string tag, input string seq);
    logic e, o;
    chkn({tag, ".len"}, len, seq.len() * C);
    chkn({tag, ".busy"}, busy_err, 0);
    for (int b = 0; b < seq.len(); b++) begin
      e = (seq[b] == "1");
      o = e;
      for (int k = 0; k < C; k++)
        if (samp[b*C+k] !== e) o = samp[b*C+k];
      chk1($sformatf("%s.bit%0d", tag, b), o, e);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst.line0", line0, 1'b1);
    chk1("rst.ready0", ready0, 1'b1);
    chk1("rst.busy0", busy0, 1'b0);
    chk1("rst.line1", line1, 1'b1);
    chk1("rst.ready1", ready1, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame A/3
    dado0 = 4'hA; instr0 = 4'h3; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0;
    capture(0);
    check_frame("a3", S_A3);
    chk1("a3.idle_line", line0, 1'b1);

    // Back-to-back frames with valid held high; dado changes while busy
    @(negedge clk);
    dado0 = 4'h1; instr0 = 4'h3; valid0 = 1'b1;
    @(posedge clk); #1 dado0 = 4'hF;
    capture(0);
    check_frame("b2b1", S_B1);
    chk1("b2b.idle_line", line0, 1'b1);
    @(posedge clk); #1 valid0 = 1'b0;
    chk1("b2b.one_idle", ready0, 1'b0);
    capture(0);
    check_frame("b2b2", S_BF);

    // Reset pulsed during the data field
    @(negedge clk);
    dado0 = 4'hA; instr0 = 4'h3; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0;
    repeat (C + 2) @(negedge clk);
    chk1("mid.pre_low", line0, 1'b0);
    rst = 1'b0;
    #1;
    chk1("mid.line", line0, 1'b1);
    chk1("mid.ready", ready0, 1'b1);
    chk1("mid.busy", busy0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    lowcnt = 0;
    for (int j = 0; j < 15 * C; j++) begin
      @(negedge clk);
      if (line0 !== 1'b1 || ready0 !== 1'b1) lowcnt++;
    end
    chkn("mid.quiet", lowcnt, 0);

    // Fresh frame after reset; dado changed the cycle after accept
    dado0 = 4'hA; instr0 = 4'h3; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0; dado0 = 4'h5;
    capture(0);
    check_frame("hold", S_A3);

    // Wide instance: 8/8 bits, 2 stop bits
    @(negedge clk);
    dado1 = 8'h55; instr1 = 8'h80; valid1 = 1'b1;
    @(posedge clk); #1 valid1 = 1'b0;
    capture(1);
    check_frame("w8", S_W8);
    chk1("w8.idle_line", line1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
